fft_stream_loader: RTL and testbench

Streaming input loader for the FFT core's sample buffer: accepts one sample per cycle on a valid/ready stream, generates the write index and registered write strobe that drive the 1-to-N demux tree into the buffer, and signals the core once a full frame of 2^N_LOG2 samples has landed. It is the writer side of the buffer whose reader side is the N-to-1 mux tree. It also checks frame length against `s_last` and stalls the stream while the core owns the buffer.

---
 rtl/fft_stream_loader.sv | 151 +++++++++++++++
 tb/tb_fft_stream_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_loader.sv
// fft_stream_loader
//   Writer side of the FFT sample buffer. Accepts one sample per cycle on a
//   valid/ready stream and produces a registered write strobe, write index and
//   write data for the 1-to-N demux tree feeding the buffer. Once a full frame
//   of 2^N_LOG2 samples has been written and has drained through the demux
//   pipeline, frame_done is raised and the stream is stalled until the core
//   returns the buffer with frame_ack. Frame length is checked against s_last.
//
//   Optional build macro: FFT_LOADER_BITREV_EN
//     defined   -> write index is the beat count with its N_LOG2 bits reversed
//                  (bit-reversed input order for decimation-in-time)
//     undefined -> write index is the beat count (natural order)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_ready   input stream handshake (s_ready decoded from state only)
//   s_data, s_last    input sample and end-of-frame marker
//   wr_en/wr_sel/wr_data  registered write to the demux tree
//   frame_done        level: buffer holds a complete frame
//   frame_err         one-cycle pulse on a framing error
//   frame_ack         core has consumed the buffer (honoured in HOLD only)
module fft_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int N_LOG2     = 11,
    parameter int PIPE_LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  wr_en,
    output logic [N_LOG2-1:0]     wr_sel,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_done,
    output logic                  frame_err,
    input  logic                  frame_ack
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Drain counter must be able to hold PIPE_LAT; keep at least one bit.
    localparam int              DCW        = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(PIPE_LAT);
    localparam logic [N_LOG2-1:0] CNT_MAX  = '1;

    logic [1:0]            state_q,      state_d;
    logic [N_LOG2-1:0]     cnt_q,        cnt_d;
    logic [DCW-1:0]        drain_q,      drain_d;
    logic                  wr_en_q,      wr_en_d;
    logic [N_LOG2-1:0]     wr_sel_q,     wr_sel_d;
    logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  frame_err_q,  frame_err_d;

    logic [N_LOG2-1:0]     idx;
    logic                  accept;

`ifdef FFT_LOADER_BITREV_EN
    for (genvar g = 0; g < N_LOG2; g++) begin : g_bitrev
        assign idx[g] = cnt_q[N_LOG2-1-g];
    end
`else
    assign idx = cnt_q;
`endif

    assign s_ready = (state_q == ST_LOAD);
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_data_d    = wr_data_q;
        frame_done_d = frame_done_q;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = idx;
                    wr_data_d = s_data;
                    if (cnt_q == CNT_MAX) begin
                        // Full frame: completed even when s_last is missing.
                        cnt_d       = '0;
                        drain_d     = '0;
                        state_d     = ST_DRAIN;
                        frame_err_d = ~s_last;
                    end else if (s_last) begin
                        // Short frame: drop it, next frame overwrites from 0.
                        cnt_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Wait out the demux pipeline so the last write has landed.
                if (drain_q == DRAIN_LAST) begin
                    drain_d      = '0;
                    state_d      = ST_HOLD;
                    frame_done_d = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    state_d      = ST_LOAD;
                    frame_done_d = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            drain_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_stream_loader.sv
// Directed bench for fft_stream_loader: small instance (N_LOG2=4, PIPE_LAT=3)
// for the frame/handshake scenarios, default-size instance for a 2048-point
// run with random valid gaps. Expected write indices follow the build macro
// FFT_LOADER_BITREV_EN.
module tb_fft_stream_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       frame_ack = 1'b0;
    logic       s_ready, wr_en, frame_done, frame_err;
    logic [3:0] wr_sel;
    logic [7:0] wr_data;

    logic        s2_valid = 1'b0;
    logic [7:0]  s2_data = '0;
    logic        s2_last = 1'b0;
    logic        frame_ack2 = 1'b0;
    logic        s2_ready, wr_en2, frame_done2, frame_err2;
    logic [10:0] wr_sel2;
    logic [7:0]  wr_data2;

    int total = 0;
    int bad   = 0;
    int n_wr2 = 0;
    int n_err2 = 0;

    // Hand-written 4-bit reversal table.
    localparam logic [3:0] BR_TAB [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                          4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    always #5 clk = ~clk;

    fft_stream_loader #(.DATA_WIDTH(8), .N_LOG2(4), .PIPE_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .frame_done(frame_done), .frame_err(frame_err),
        .frame_ack(frame_ack)
    );

    fft_stream_loader dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s2_valid), .s_ready(s2_ready),
        .s_data(s2_data), .s_last(s2_last), .wr_en(wr_en2), .wr_sel(wr_sel2),
        .wr_data(wr_data2), .frame_done(frame_done2), .frame_err(frame_err2),
        .frame_ack(frame_ack2)
    );

    always @(negedge clk) begin
        if (wr_en2 === 1'b1)     n_wr2  <= n_wr2 + 1;
        if (frame_err2 === 1'b1) n_err2 <= n_err2 + 1;
    end

    function automatic logic [3:0] exp_idx(input int i);
`ifdef FFT_LOADER_BITREV_EN
        return BR_TAB[i];
`else
        return 4'(i);
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; frame_ack = 1'b0;
        s2_valid = 1'b0; s2_last = 1'b0; frame_ack2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents one beat and advances to the negedge after the accepting edge.
    task automatic beat(input logic [7:0] d, input logic l);
        s_valid = 1'b1; s_data = d; s_last = l;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h55;
        repeat (3) @(negedge clk);
        total++; if (wr_en !== 1'b0)      begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
        total++; if (wr_sel !== 4'd0)     begin bad++; $display("FAIL rst_wr_sel got=%h exp=0", wr_sel); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_release_wr_en got=%b exp=0", wr_en); end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            beat(8'h10 + 8'(i), i == 15);
            total++; if (wr_en !== 1'b1)        begin bad++; $display("FAIL ff_wr_en[%0d] got=%b exp=1", i, wr_en); end
            total++; if (wr_sel !== exp_idx(i)) begin bad++; $display("FAIL ff_wr_sel[%0d] got=%h exp=%h", i, wr_sel, exp_idx(i)); end
            total++; if (wr_data !== 8'h10 + 8'(i)) begin bad++; $display("FAIL ff_wr_data[%0d] got=%h exp=%h", i, wr_data, 8'h10 + 8'(i)); end
            total++; if (frame_err !== 1'b0)    begin bad++; $display("FAIL ff_frame_err[%0d] got=%b exp=0", i, frame_err); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ff_early_done[%0d] got=%b exp=0", c, frame_done); end
            total++; if (s_ready !== 1'b0)    begin bad++; $display("FAIL ff_drain_ready[%0d] got=%b exp=0", c, s_ready); end
        end
        @(negedge clk);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ff_done_rise got=%b exp=1", frame_done); end
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ff_ack_done got=%b exp=0", frame_done); end
        total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL ff_ack_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_early_last();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            beat(8'(i), i == 5);
            total++; if (frame_err !== (i == 5)) begin bad++; $display("FAIL el_frame_err[%0d] got=%b exp=%b", i, frame_err, i == 5); end
        end
        beat(8'hA6, 1'b0);
        total++; if (wr_sel !== exp_idx(0)) begin bad++; $display("FAIL el_restart_sel got=%h exp=%h", wr_sel, exp_idx(0)); end
        total++; if (frame_err !== 1'b0)    begin bad++; $display("FAIL el_err_width got=%b exp=0", frame_err); end
        s_valid = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL el_no_done got=%b exp=0", frame_done); end
        total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL el_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_missing_last();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            beat(8'(i), 1'b0);
            total++; if (frame_err !== (i == 15)) begin bad++; $display("FAIL ml_frame_err[%0d] got=%b exp=%b", i, frame_err, i == 15); end
        end
        s_valid = 1'b0;
        @(negedge clk);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ml_err_width got=%b exp=0", frame_err); end
        repeat (2) @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ml_done_early got=%b exp=0", frame_done); end
        @(negedge clk);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ml_done got=%b exp=1", frame_done); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 16; i++) beat(8'(i), i == 15);
        s_last = 1'b0; s_data = 8'hEE;   // s_valid stays high
        for (int c = 1; c <= 8; c++) begin
            frame_ack = (c == 1);        // ack during DRAIN must be ignored
            @(negedge clk);
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, s_ready); end
            total++; if (wr_en !== 1'b0)   begin bad++; $display("FAIL bp_wr_en[%0d] got=%b exp=0", c, wr_en); end
            total++; if (frame_done !== (c >= 4)) begin bad++; $display("FAIL bp_done[%0d] got=%b exp=%b", c, frame_done, c >= 4); end
        end
        s_data = 8'hAA;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        total++; if (wr_en !== 1'b0)      begin bad++; $display("FAIL bp_ack_no_accept got=%b exp=0", wr_en); end
        total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL bp_ack_ready got=%b exp=1", s_ready); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL bp_ack_done got=%b exp=0", frame_done); end
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (wr_en !== 1'b1)        begin bad++; $display("FAIL bp_next_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_sel !== exp_idx(0)) begin bad++; $display("FAIL bp_next_sel got=%h exp=%h", wr_sel, exp_idx(0)); end
        total++; if (wr_data !== 8'hAA)     begin bad++; $display("FAIL bp_next_data got=%h exp=aa", wr_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) beat(8'h30 + 8'(i), 1'b0);
        total++; if (wr_sel !== exp_idx(7)) begin bad++; $display("FAIL rm_sel7 got=%h exp=%h", wr_sel, exp_idx(7)); end
        rst_n = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0)   begin bad++; $display("FAIL rm_async_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_sel !== 4'd0)  begin bad++; $display("FAIL rm_async_sel got=%h exp=0", wr_sel); end
        total++; if (wr_data !== 8'd0) begin bad++; $display("FAIL rm_async_data got=%h exp=0", wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'h77, 1'b0);
        s_valid = 1'b0;
        total++; if (wr_sel !== exp_idx(0)) begin bad++; $display("FAIL rm_restart_sel got=%h exp=%h", wr_sel, exp_idx(0)); end
        total++; if (wr_data !== 8'h77)     begin bad++; $display("FAIL rm_restart_data got=%h exp=77", wr_data); end
        total++; if (frame_done !== 1'b0)   begin bad++; $display("FAIL rm_done got=%b exp=0", frame_done); end
    endtask

    task automatic test_random_2048();
        int start_wr, start_err;
        do_reset();
        #1;
        start_wr = n_wr2; start_err = n_err2;
        for (int i = 0; i < 2048; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                s2_valid = 1'b0;
                @(negedge clk);
            end
            s2_valid = 1'b1; s2_data = i[7:0]; s2_last = (i == 2047);
            @(negedge clk);
        end
        s2_valid = 1'b0; s2_last = 1'b0;
        total++; if (wr_sel2 !== 11'h7FF) begin bad++; $display("FAIL rn_last_sel got=%h exp=7ff", wr_sel2); end
        repeat (4) @(negedge clk);
        #1;
        total++; if (n_wr2 - start_wr !== 2048) begin bad++; $display("FAIL rn_wr_count got=%0d exp=2048", n_wr2 - start_wr); end
        total++; if (n_err2 - start_err !== 0)  begin bad++; $display("FAIL rn_err_count got=%0d exp=0", n_err2 - start_err); end
        total++; if (frame_done2 !== 1'b1)      begin bad++; $display("FAIL rn_done got=%b exp=1", frame_done2); end
        frame_ack2 = 1'b1;
        @(negedge clk);
        frame_ack2 = 1'b0;
        total++; if (s2_ready !== 1'b1) begin bad++; $display("FAIL rn_ack_ready got=%b exp=1", s2_ready); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_reset_mid();
        test_random_2048();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
